// File: rtl/slc3_mem_pkg.sv
// rtl/slc3_mem_pkg.sv - shared types and constants for the SLC-3 memory responder
package slc3_mem_pkg;

  typedef enum logic {
    S_INIT,
    S_READY
  } mem_state_t;

  typedef enum logic [1:0] {
    T_RAM,
    T_IO,
    T_NONE
  } target_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          READ_LAT        = 2;

endpackage

// File: rtl/slc3_mem_responder_if.sv
// rtl/slc3_mem_responder_if.sv - CPU-side memory request/response bundle plus board I/O
interface slc3_mem_responder_if;

  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] sw_i;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        init_done;
  logic [15:0] hex_o;

  // CPU control / board side drives requests and switches
  modport master (
    output mem_mem_ena, mem_wr_ena, mem_addr, mem_wdata, sw_i,
    input  mem_rdata, mem_rvalid, init_done, hex_o
  );

  // Responder side serves requests and drives the display
  modport slave (
    input  mem_mem_ena, mem_wr_ena, mem_addr, mem_wdata, sw_i,
    output mem_rdata, mem_rvalid, init_done, hex_o
  );

endinterface

// File: rtl/slc3_init_rom.sv
// rtl/slc3_init_rom.sv - combinational program image copied into RAM after reset
module slc3_init_rom #(
  parameter int INIT_LEN    = 64,
  parameter int IMAGE_WORDS = 56,
  parameter int AW          = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1
) (
  input  logic [AW-1:0] i_addr,
  output logic [15:0]   o_data
);

  // Image word i is 0x1000 + i*0x0137; words past the image end read as zero
  always_comb begin
    o_data = 16'h0000;
    if (int'(i_addr) < IMAGE_WORDS) begin
      o_data = 16'h1000 + 16'(i_addr) * 16'h0137;
    end
  end

endmodule

// File: rtl/slc3_mem_responder.sv
// rtl/slc3_mem_responder.sv - program RAM, image loader and I/O word for the SLC-3 CPU
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter int          INIT_LEN  = 64,
  parameter logic [15:0] IO_ADDR   = IO_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  slc3_mem_responder_if.slave  bus
);

  localparam int                RAM_AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int                ROM_AW   = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;
  localparam logic [ROM_AW-1:0] LAST_CNT = ROM_AW'(INIT_LEN - 1);

  logic [15:0]         r_ram [MEM_DEPTH];
  mem_state_t          r_state;
  logic [ROM_AW-1:0]   r_cnt;
  logic                r_init_done;
  logic [READ_LAT-1:0] r_vld;
  target_t             r_s1_tgt;
  logic [15:0]         r_s1_ram;
  logic [15:0]         r_s1_sw;
  logic [15:0]         r_rdata;
  logic [15:0]         r_hex;

  logic [15:0]         w_rom_data;
  logic                w_init_wr;
  logic                w_rd;
  logic                w_wr;
  target_t             w_tgt;
  logic [RAM_AW-1:0]   w_ram_idx;
  logic [RAM_AW-1:0]   w_init_idx;
  logic [RAM_AW-1:0]   w_port_idx;
  logic                w_ram_we;
  logic [15:0]         w_ram_wd;
  logic [15:0]         w_s1_data;

  slc3_init_rom #(
    .INIT_LEN (INIT_LEN),
    .AW       (ROM_AW)
  ) u_rom (
    .i_addr (r_cnt),
    .o_data (w_rom_data)
  );

  // CPU requests are only honoured once the image is loaded; reset blocks side effects
  assign w_init_wr  = reset && (r_state == S_INIT);
  assign w_rd       = reset && (r_state == S_READY) && bus.mem_mem_ena && !bus.mem_wr_ena;
  assign w_wr       = reset && (r_state == S_READY) && bus.mem_mem_ena && bus.mem_wr_ena;
  assign w_ram_idx  = bus.mem_addr[RAM_AW-1:0];
  assign w_init_idx = RAM_AW'(r_cnt);

  // One shared RAM port: the loader owns it during init, the CPU afterwards
  assign w_port_idx = (r_state == S_INIT) ? w_init_idx : w_ram_idx;
  assign w_ram_we   = w_init_wr || (w_wr && (w_tgt == T_RAM));
  assign w_ram_wd   = (r_state == S_INIT) ? w_rom_data : bus.mem_wdata;

  // Address decode: RAM window, the single I/O word, everything else unmapped
  always_comb begin
    w_tgt = T_NONE;
    if (int'(bus.mem_addr) < MEM_DEPTH) begin
      w_tgt = T_RAM;
    end else if (bus.mem_addr == IO_ADDR) begin
      w_tgt = T_IO;
    end
  end

  // Single-port RAM with synchronous read; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_port_idx] <= w_ram_wd;
    end
    r_s1_ram <= r_ram[w_port_idx];
  end

  // Stage-2 source select from the target captured in stage 1
  always_comb begin
    case (r_s1_tgt)
      T_RAM:   w_s1_data = r_s1_ram;
      T_IO:    w_s1_data = r_s1_sw;
      default: w_s1_data = 16'h0000;
    endcase
  end

  // Loader FSM, two-stage read pipeline and hex register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_vld       <= '0;
      r_s1_tgt    <= T_NONE;
      r_s1_sw     <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_hex       <= 16'h0000;
    end else begin
      case (r_state)
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_READY;
        end
      endcase

      r_vld <= {r_vld[READ_LAT-2:0], w_rd};

      if (w_rd) begin
        r_s1_tgt <= w_tgt;
        r_s1_sw  <= bus.sw_i;
      end

      if (r_vld[READ_LAT-2]) begin
        r_rdata <= w_s1_data;
      end

      if (w_wr && (w_tgt == T_IO)) begin
        r_hex <= bus.mem_wdata;
      end
    end
  end

  assign bus.mem_rdata  = r_rdata;
  assign bus.mem_rvalid = r_vld[READ_LAT-1];
  assign bus.init_done  = r_init_done;
  assign bus.hex_o      = r_hex;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// tb/tb_slc3_mem_responder.sv - scoreboard bench for the SLC-3 memory responder
module tb_slc3_mem_responder;

  localparam int MEM_DEPTH   = 256;
  localparam int INIT_LEN    = 64;
  localparam int IMAGE_WORDS = 56;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  slc3_mem_responder_if bus();

  slc3_mem_responder #(
    .MEM_DEPTH (MEM_DEPTH),
    .INIT_LEN  (INIT_LEN),
    .IO_ADDR   (16'hFFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          init_cnt = 0;
  bit          started = 1'b0;
  logic [15:0] m_ram [MEM_DEPTH];
  logic [15:0] m_hex  = 16'h0000;
  logic [15:0] hold   = 16'h0000;
  exp_t        exp_q[$];

  function automatic logic [15:0] rom_word(input int i);
    int v;
    v = 'h1000 + i * 'h137;
    return (i < IMAGE_WORDS) ? v[15:0] : 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: sees each request at the edge that accepts it
  always @(posedge clk) begin
    exp_t e;
    int   a;
    cyc = cyc + 1;
    if (!reset) begin
      started = 1'b1;
      exp_q.delete();
      m_hex    = 16'h0000;
      hold     = 16'h0000;
      init_cnt = 0;
      for (int i = 0; i < INIT_LEN; i++) m_ram[i] = rom_word(i);
    end else begin
      a = int'(bus.mem_addr);
      if (init_cnt == INIT_LEN && bus.mem_mem_ena) begin
        if (bus.mem_wr_ena) begin
          if (a < MEM_DEPTH) m_ram[a] = bus.mem_wdata;
          else if (a == 'hFFFF) m_hex = bus.mem_wdata;
        end else begin
          e.due = cyc + 1;
          if (a < MEM_DEPTH) e.data = m_ram[a];
          else if (a == 'hFFFF) e.data = bus.sw_i;
          else e.data = 16'h0000;
          exp_q.push_back(e);
        end
      end
      if (init_cnt < INIT_LEN) init_cnt++;
    end
  end

  // Monitor: compares DUT outputs away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("rvalid_at_due", 32'(bus.mem_rvalid), 32'(1));
        chk("rvalid_latency", 32'(cyc), 32'(e.due));
        hold = e.data;
      end else begin
        chk("rvalid_idle", 32'(bus.mem_rvalid), 32'(0));
      end
      chk("rdata", 32'(bus.mem_rdata), 32'(hold));
      chk("init_done", 32'(bus.init_done), 32'(init_cnt == INIT_LEN));
      chk("hex_o", 32'(bus.hex_o), 32'(m_hex));
    end
  end

  task automatic drive(input logic ena, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] sw);
    @(posedge clk);
    #1;
    bus.mem_mem_ena = ena;
    bus.mem_wr_ena  = wr;
    bus.mem_addr    = addr;
    bus.mem_wdata   = wd;
    bus.sw_i        = sw;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 16'h0000);
  endtask

  initial begin
    logic [15:0] ra;
    int          pick;
    bus.mem_mem_ena = 1'b0;
    bus.mem_wr_ena  = 1'b0;
    bus.mem_addr    = 16'h0000;
    bus.mem_wdata   = 16'h0000;
    bus.sw_i        = 16'h0000;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Init window: a write attempted mid-load must be ignored
    idle(10);
    drive(1'b1, 1'b1, 16'h0003, 16'hDEAD, 16'h0000);
    idle(60);

    // Image readback, back to back
    for (int i = 0; i < INIT_LEN; i++) drive(1'b1, 1'b0, 16'(i), 16'h0000, 16'h0000);
    idle(3);

    // Single read then idle: data must hold
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000);
    idle(4);

    // Write then immediate readback, interleaved reads
    drive(1'b1, 1'b1, 16'h0010, 16'h1234, 16'h0000);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
    idle(3);

    // Give the upper RAM words known contents
    for (int i = INIT_LEN; i < MEM_DEPTH; i++) drive(1'b1, 1'b1, 16'(i), 16'($urandom), 16'h0000);

    // I/O word, unmapped space and RAM boundary
    drive(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000);
    drive(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h00A5);
    drive(1'b1, 1'b1, 16'h0200, 16'h5555, 16'h0000);
    drive(1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000);
    drive(1'b1, 1'b1, 16'h00FF, 16'hCAFE, 16'h0000);
    drive(1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000);
    idle(3);

    // Randomised traffic across RAM, I/O and unmapped addresses
    for (int i = 0; i < 800; i++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 60) ra = 16'($urandom_range(0, MEM_DEPTH - 1));
      else if (pick < 75) ra = 16'hFFFF;
      else ra = 16'($urandom_range(MEM_DEPTH, 'hFFFE));
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 2) == 0), ra,
            16'($urandom), 16'($urandom));
    end
    idle(3);

    // Reset while a read is in flight
    drive(1'b1, 1'b1, 16'hFFFF, 16'h1357, 16'h0000);
    drive(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    reset           = 1'b0;
    bus.mem_mem_ena = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    idle(5);
    drive(1'b1, 1'b1, 16'h0003, 16'hDEAD, 16'h0000);
    idle(62);
    drive(1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
    idle(5);

    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
